// File: rtl/rsa_pkg.sv
// Shared constants and state encodings for the RSA modular-exponentiation datapath.
// The Montgomery multiplier takes its modulus from here as well, so both sides agree on M.
package rsa_pkg;

    localparam int K    = 192;
    localparam int LOGK = 8;

    localparam logic [K-1:0] M  = 192'hfffffffffffffffffffffffffffffffeffffffffffffffff;
    localparam logic [K-1:0] R2 = 192'h000000000000000100000000000000020000000000000001;

    typedef enum logic [2:0] {
        IDLE,
        CONV_X,
        CONV_ONE,
        SQUARE,
        MULT,
        CONV_OUT,
        FINISH
    } main_state_e;

    typedef enum logic [1:0] {
        H_PREP,
        H_REQ,
        H_WAIT
    } hs_state_e;

endpackage

// File: rtl/mont_mul_if.sv
// Initiator side of the start/done level handshake to the shared Montgomery multiplier.
// One multiplication per req-qualified pass through H_PREP -> H_REQ -> H_WAIT; ack marks the capture edge.
module mont_mul_if #(
    parameter int K = rsa_pkg::K
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req,
    input  logic [K-1:0] x,
    input  logic [K-1:0] y,
    output logic         ack,
    output logic [K-1:0] z,
    output logic [K-1:0] mul_x,
    output logic [K-1:0] mul_y,
    output logic         mul_start,
    input  logic         mul_done,
    input  logic [K-1:0] mul_z
);

    import rsa_pkg::*;

    hs_state_e hs_q, hs_d;
    logic      mul_start_q, mul_start_d;

    // H_PREP doubles as the resting state; req holds it back until the schedule has an operation.
    always_comb begin
        hs_d        = hs_q;
        mul_start_d = 1'b0;
        unique case (hs_q)
            H_PREP: begin
                if (req && mul_done) begin
                    hs_d        = H_REQ;
                    mul_start_d = 1'b1;
                end
            end
            H_REQ: begin
                if (mul_done) begin
                    mul_start_d = 1'b1;
                end else begin
                    hs_d = H_WAIT;
                end
            end
            H_WAIT: begin
                if (mul_done) begin
                    hs_d = H_PREP;
                end
            end
            default: hs_d = H_PREP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hs_q        <= H_PREP;
            mul_start_q <= 1'b0;
        end else begin
            hs_q        <= hs_d;
            mul_start_q <= mul_start_d;
        end
    end

    // Operands come from the schedule's registers, selected by its registered state.
    assign mul_x     = x;
    assign mul_y     = y;
    assign mul_start = mul_start_q;
    assign ack       = (hs_q == H_WAIT) && mul_done;
    assign z         = mul_z;

endmodule

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer computing base^exponent mod M through
// the shared Montgomery multiplier, including conversion into and out of the Montgomery domain.
module mod_exp_ctrl #(
    parameter int           K    = rsa_pkg::K,
    parameter int           LOGK = rsa_pkg::LOGK,
    parameter logic [K-1:0] M    = rsa_pkg::M,
    parameter logic [K-1:0] R2   = rsa_pkg::R2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [K-1:0] base,
    input  logic [K-1:0] exponent,
    output logic         busy,
    output logic         done,
    output logic [K-1:0] result,
    output logic [K-1:0] mul_x,
    output logic [K-1:0] mul_y,
    output logic         mul_start,
    input  logic         mul_done,
    input  logic [K-1:0] mul_z
);

    import rsa_pkg::*;

    localparam logic [K-1:0] ONE = K'(1);

    if (M[0] == 1'b0) begin : g_even_modulus
        $error("mod_exp_ctrl: Montgomery reduction needs an odd modulus M");
    end

    main_state_e     state_q, state_d;
    logic [K-1:0]    xm_q, xm_d;
    logic [K-1:0]    acc_q, acc_d;
    logic [K-1:0]    exp_q, exp_d;
    logic [LOGK-1:0] idx_q, idx_d;
    logic [K-1:0]    result_q, result_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [K-1:0]    op_x, op_y;
    logic            mm_ack;
    logic [K-1:0]    mm_z;
    logic            last_bit;
    main_state_e     step_state;
    logic [LOGK-1:0] step_idx;

    // Index step shared by SQUARE (bit clear) and MULT: idx never wraps below zero.
    assign last_bit   = (idx_q == '0);
    assign step_state = last_bit ? CONV_OUT : SQUARE;
    assign step_idx   = last_bit ? idx_q : idx_q - LOGK'(1);

    // xm holds the raw base until CONV_X replaces it with its Montgomery form.
    always_comb begin
        state_d  = state_q;
        xm_d     = xm_q;
        acc_d    = acc_q;
        exp_d    = exp_q;
        idx_d    = idx_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        op_x     = '0;
        op_y     = '0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CONV_X;
                    xm_d    = base;
                    exp_d   = exponent;
                    idx_d   = LOGK'(K - 1);
                    busy_d  = 1'b1;
                end
            end
            CONV_X: begin
                op_x = xm_q;
                op_y = R2;
                if (mm_ack) begin
                    xm_d    = mm_z;
                    state_d = CONV_ONE;
                end
            end
            CONV_ONE: begin
                op_x = ONE;
                op_y = R2;
                if (mm_ack) begin
                    acc_d   = mm_z;
                    state_d = SQUARE;
                end
            end
            SQUARE: begin
                op_x = acc_q;
                op_y = acc_q;
                if (mm_ack) begin
                    acc_d = mm_z;
                    if (exp_q[idx_q]) begin
                        state_d = MULT;
                    end else begin
                        state_d = step_state;
                        idx_d   = step_idx;
                    end
                end
            end
            MULT: begin
                op_x = acc_q;
                op_y = xm_q;
                if (mm_ack) begin
                    acc_d   = mm_z;
                    state_d = step_state;
                    idx_d   = step_idx;
                end
            end
            CONV_OUT: begin
                op_x = acc_q;
                op_y = ONE;
                if (mm_ack) begin
                    acc_d    = mm_z;
                    result_d = mm_z;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
        xm_q  <= xm_d;
        acc_q <= acc_d;
        exp_q <= exp_d;
        idx_q <= idx_d;
    end

    // busy is high exactly while a multiplication-issuing state is active.
    mont_mul_if #(
        .K(K)
    ) u_mont_mul_if (
        .clk       (clk),
        .reset     (reset),
        .req       (busy_q),
        .x         (op_x),
        .y         (op_y),
        .ack       (mm_ack),
        .z         (mm_z),
        .mul_x     (mul_x),
        .mul_y     (mul_y),
        .mul_start (mul_start),
        .mul_done  (mul_done),
        .mul_z     (mul_z)
    );

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Directed bench for mod_exp_ctrl against a behavioural Montgomery multiplier on the same handshake.
module tb_mod_exp_ctrl;

    import rsa_pkg::*;

    localparam int LAT = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [K-1:0] base;
    logic [K-1:0] exponent;
    logic         busy;
    logic         done;
    logic [K-1:0] result;
    logic [K-1:0] mul_x;
    logic [K-1:0] mul_y;
    logic         mul_start;
    logic         mul_done;
    logic [K-1:0] mul_z;

    int n_checks = 0;
    int n_fail   = 0;
    int start_rises = 0;
    int done_pulses = 0;
    logic start_prev = 1'b0;
    int mbusy = 0;

    always #5 clk = ~clk;

    mod_exp_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base      (base),
        .exponent  (exponent),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .mul_x     (mul_x),
        .mul_y     (mul_y),
        .mul_start (mul_start),
        .mul_done  (mul_done),
        .mul_z     (mul_z)
    );

    // x*y*2^-K mod M, bit-serial
    function automatic logic [K-1:0] mont_ref(input logic [K-1:0] x, input logic [K-1:0] y);
        logic [K+1:0] a;
        a = '0;
        for (int i = 0; i < K; i++) begin
            if (x[i]) a = a + {2'b00, y};
            if (a[0]) a = a + {2'b00, M};
            a = a >> 1;
        end
        if (a >= {2'b00, M}) a = a - {2'b00, M};
        return a[K-1:0];
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            mul_done <= 1'b1;
            mbusy    <= 0;
        end else if (mul_done && mul_start) begin
            mul_done <= 1'b0;
            mbusy    <= LAT;
            mul_z    <= mont_ref(mul_x, mul_y);
        end else if (!mul_done) begin
            if (mbusy > 0) mbusy <= mbusy - 1;
            else if (!mul_start) mul_done <= 1'b1;
        end
    end

    always @(posedge clk) begin
        start_prev <= mul_start;
        if (mul_start && !start_prev) start_rises <= start_rises + 1;
        if (done) done_pulses <= done_pulses + 1;
    end

    task automatic check(input string tag, input logic [K-1:0] got, input logic [K-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic run(input string tag, input logic [K-1:0] b, input logic [K-1:0] e,
                       input logic [K-1:0] want, input int want_mults, input int mid_start);
        int r0;
        int d0;
        bit seen;
        r0   = start_rises;
        d0   = done_pulses;
        seen = 1'b0;
        base     = b;
        exponent = e;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy"}, K'(busy), K'(1));
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            start = (mid_start != 0 && cyc == mid_start);
            if (start) begin
                base     = K'(7);
                exponent = K'(3);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        check({tag, "_done_seen"}, K'(seen), K'(1));
        check({tag, "_result"}, result, want);
        check({tag, "_busy_at_done"}, K'(busy), K'(0));
        check({tag, "_mults"}, K'(start_rises - r0), K'(want_mults));
        @(posedge clk); #1;
        check({tag, "_done_low"}, K'(done), K'(0));
        check({tag, "_result_held"}, result, want);
        check({tag, "_done_pulses"}, K'(done_pulses - d0), K'(1));
    endtask

    task automatic reset_mid(input string tag, input int nth_rise, input bit in_wait);
        int r0;
        bit hit;
        r0  = start_rises;
        hit = 1'b0;
        base     = K'(2);
        exponent = K'(10);
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if ((start_rises - r0 >= nth_rise) &&
                (in_wait ? (!mul_start && !mul_done) : mul_start)) begin
                hit = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check({tag, "_reached"}, K'(hit), K'(1));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check({tag, "_busy"}, K'(busy), K'(0));
        check({tag, "_done"}, K'(done), K'(0));
        check({tag, "_mul_start"}, K'(mul_start), K'(0));
        check({tag, "_result"}, result, K'(0));
        check({tag, "_mul_x"}, mul_x, K'(0));
        check({tag, "_mul_y"}, mul_y, K'(0));
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        base     = '0;
        exponent = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", K'(busy), K'(0));
        check("rst_done", K'(done), K'(0));
        check("rst_result", result, K'(0));
        check("rst_mul_start", K'(mul_start), K'(0));
        check("rst_mul_x", mul_x, K'(0));
        check("rst_mul_y", mul_y, K'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        run("pow2_10", K'(2), K'(10), K'(1024), 197, 0);
        run("exp_zero", K'(5), K'(0), K'(1), 195, 0);
        run("mm1_e1", M - K'(1), K'(1), M - K'(1), 196, 0);
        run("mm1_e2", M - K'(1), K'(2), K'(1), 196, 0);
        run("zero_base", K'(0), K'(5), K'(0), 197, 0);
        run("fermat", K'(3), M - K'(1), K'(1), 385, 0);
        run("start_busy", K'(2), K'(10), K'(1024), 197, 50);

        reset_mid("rst_req", 3, 1'b0);
        run("after_rst_req", K'(2), K'(10), K'(1024), 197, 0);
        reset_mid("rst_wait", 4, 1'b1);
        run("after_rst_wait", K'(2), K'(10), K'(1024), 197, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
